// File: rtl/clause_gather_fifo.sv
// ============================================================================
//  Module      : clause_gather_fifo
//  Description : Accepts a wide vector of clauses with a per-clause valid mask
//                into a staging register, compacts the valid clauses into a
//                circular buffer (up to DRAIN_WIDTH per cycle, ascending index
//                order) and presents one clause per cycle with first-word-
//                fall-through reads, input backpressure and a sticky overflow.
//  Options     : CLAUSE_GATHER_LAST_TAG_EN adds clause_last_o, marking the
//                highest-index valid clause of each batch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clause_gather_fifo #(
    parameter int CLAUSE_COUNT = 20,
    parameter int CLAUSE_WIDTH = 9,
    parameter int BUFFER_DEPTH = 16,
    parameter int DRAIN_WIDTH  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0]  clauses_i,
    input  logic [CLAUSE_COUNT-1:0]               clause_valid_i,
    input  logic                                  wren,
    output logic                                  ready,
    input  logic                                  rden,
    input  logic                                  cOF,
    output logic                                  empty,
    output logic                                  full,
    output logic                                  OF,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]     count,
    output logic [CLAUSE_WIDTH-1:0]               clause_o
`ifdef CLAUSE_GATHER_LAST_TAG_EN
    ,
    output logic                                  clause_last_o
`endif
);

    // Occupancy needs one more state than pointers (0..BUFFER_DEPTH).
    localparam int c_cnt_w = $clog2(BUFFER_DEPTH + 1);
    localparam int c_ptr_w = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    // More lanes than buffer slots could never be used in one cycle.
    localparam int c_lanes = (DRAIN_WIDTH < BUFFER_DEPTH) ? DRAIN_WIDTH : BUFFER_DEPTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0] r_stage_data;
    logic [CLAUSE_COUNT-1:0]              r_stage_mask;
    logic [c_ptr_w-1:0]                   r_rd_ptr;
    logic [c_ptr_w-1:0]                   r_wr_ptr;
    logic [c_cnt_w-1:0]                   r_count;
    logic                                 r_of;
    logic [CLAUSE_WIDTH-1:0]              r_mem [BUFFER_DEPTH];
`ifdef CLAUSE_GATHER_LAST_TAG_EN
    logic                                 r_tag [BUFFER_DEPTH];
`endif

    // ------------------------------------------------------------------
    // Combinational drain selection
    // ------------------------------------------------------------------
    logic                                 w_ready;
    logic                                 w_accept;
    logic                                 w_drop;
    logic                                 w_pop;
    logic [c_cnt_w-1:0]                   w_free;
    logic [c_cnt_w-1:0]                   w_limit;
    logic [c_cnt_w-1:0]                   w_run;
    logic [c_cnt_w-1:0]                   w_n;
    logic [c_cnt_w-1:0]                   w_rank [CLAUSE_COUNT];
    logic [CLAUSE_COUNT-1:0]              w_take;
    logic [c_lanes-1:0]                   w_lane_vld;
    logic [CLAUSE_WIDTH-1:0]              w_lane_data [c_lanes];
`ifdef CLAUSE_GATHER_LAST_TAG_EN
    logic [CLAUSE_COUNT-1:0]              w_top;
    logic                                 w_seen;
    logic [c_lanes-1:0]                   w_lane_last;
`endif

    // Staging is free only once every mask bit has drained; no look-ahead.
    assign w_ready  = (r_stage_mask == '0);
    assign w_accept = wren & w_ready;
    assign w_drop   = wren & ~w_ready;
    assign w_pop    = rden & (r_count != '0);

    // Free space is taken before this cycle's pop, giving a one-cycle margin.
    assign w_free  = c_cnt_w'(BUFFER_DEPTH) - r_count;
    assign w_limit = (w_free < c_cnt_w'(c_lanes)) ? w_free : c_cnt_w'(c_lanes);

    // Rank each staged clause among set bits; take the lowest w_limit of them.
    always_comb begin
        w_take = '0;
        w_run  = '0;
        for (int j = 0; j < CLAUSE_COUNT; j++) begin
            w_rank[j] = w_run;
            if (r_stage_mask[j] && (w_run < w_limit)) begin
                w_take[j] = 1'b1;
                w_run     = w_run + c_cnt_w'(1);
            end
        end
        w_n = w_run;
    end

`ifdef CLAUSE_GATHER_LAST_TAG_EN
    // The highest remaining set bit is the batch's last clause, since bits
    // only ever clear from the bottom up.
    always_comb begin
        w_top  = '0;
        w_seen = 1'b0;
        for (int j = CLAUSE_COUNT - 1; j >= 0; j--) begin
            if (r_stage_mask[j] && !w_seen) begin
                w_top[j] = 1'b1;
            end
            w_seen = w_seen | r_stage_mask[j];
        end
    end
`endif

    // Route the taken clauses onto write lanes ordered by rank.
    always_comb begin
        w_lane_vld = '0;
`ifdef CLAUSE_GATHER_LAST_TAG_EN
        w_lane_last = '0;
`endif
        for (int k = 0; k < c_lanes; k++) begin
            w_lane_data[k] = '0;
            for (int j = 0; j < CLAUSE_COUNT; j++) begin
                if (w_take[j] && (w_rank[j] == c_cnt_w'(k))) begin
                    w_lane_vld[k]  = 1'b1;
                    w_lane_data[k] = r_stage_data[j*CLAUSE_WIDTH +: CLAUSE_WIDTH];
`ifdef CLAUSE_GATHER_LAST_TAG_EN
                    w_lane_last[k] = w_top[j];
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Staging register: load on accept, otherwise retire drained bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage_mask <= '0;
            r_stage_data <= '0;
        end else if (w_accept) begin
            r_stage_mask <= clause_valid_i;
            r_stage_data <= clauses_i;
        end else begin
            r_stage_mask <= r_stage_mask & ~w_take;
        end
    end

    // Buffer storage is intentionally not reset; count gates its visibility.
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_lanes; k++) begin
            if (w_lane_vld[k]) begin
                r_mem[r_wr_ptr + c_ptr_w'(k)] <= w_lane_data[k];
`ifdef CLAUSE_GATHER_LAST_TAG_EN
                r_tag[r_wr_ptr + c_ptr_w'(k)] <= w_lane_last[k];
`endif
            end
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks n - pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_n);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + w_n - c_cnt_w'(w_pop);
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_of <= 1'b0;
        end else if (w_drop) begin
            r_of <= 1'b1;
        end else if (cOF) begin
            r_of <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready    = w_ready;
    assign empty    = (r_count == '0);
    assign full     = (r_count == c_cnt_w'(BUFFER_DEPTH));
    assign OF       = r_of;
    assign count    = r_count;
    assign clause_o = empty ? '0 : r_mem[r_rd_ptr];
`ifdef CLAUSE_GATHER_LAST_TAG_EN
    assign clause_last_o = empty ? 1'b0 : r_tag[r_rd_ptr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_clause_gather_fifo.sv
// ============================================================================
//  Module      : tb_clause_gather_fifo
//  Description : Self-checking bench for clause_gather_fifo with directed
//                scenarios and a queue-based reference model for random runs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clause_gather_fifo;

    localparam int CC = 20;
    localparam int CW = 9;
    localparam int BD = 16;
    localparam int DW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [CC*CW-1:0] clauses_i;
    logic [CC-1:0]  clause_valid_i;
    logic           wren, rden, cOF;
    logic           ready, empty, full, OF;
    logic [4:0]     count;
    logic [CW-1:0]  clause_o;
`ifdef CLAUSE_GATHER_LAST_TAG_EN
    logic           clause_last_o;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: staged clauses and buffered clauses as queues of {last,data}.
    logic [CW:0]    m_stage[$];
    logic [CW:0]    m_buf[$];
    logic           m_of;

    logic [CW-1:0]  got[$];
    logic           got_last[$];

    always #5 clk = ~clk;

    clause_gather_fifo #(
        .CLAUSE_COUNT(CC), .CLAUSE_WIDTH(CW), .BUFFER_DEPTH(BD), .DRAIN_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .clauses_i(clauses_i), .clause_valid_i(clause_valid_i),
        .wren(wren), .ready(ready), .rden(rden), .cOF(cOF), .empty(empty), .full(full),
        .OF(OF), .count(count), .clause_o(clause_o)
`ifdef CLAUSE_GATHER_LAST_TAG_EN
        , .clause_last_o(clause_last_o)
`endif
    );

    function automatic logic [CC*CW-1:0] rand_vec();
        logic [CC*CW-1:0] v;
        for (int j = 0; j < CC; j++) v[j*CW +: CW] = CW'($urandom);
        return v;
    endfunction

    function automatic logic [CW-1:0] slice(input logic [CC*CW-1:0] v, input int j);
        return v[j*CW +: CW];
    endfunction

    task automatic model_reset();
        m_stage.delete();
        m_buf.delete();
        m_of = 1'b0;
    endtask

    // One clock edge of the specification's rules, applied to the queues.
    task automatic model_step(input logic w, input logic [CC-1:0] m,
                              input logic [CC*CW-1:0] d, input logic r, input logic c);
        int  n;
        int  top;
        bit  rdy;
        rdy = (m_stage.size() == 0);
        n = DW;
        if (m_stage.size() < n) n = m_stage.size();
        if (BD - m_buf.size() < n) n = BD - m_buf.size();
        if (r && m_buf.size() > 0) void'(m_buf.pop_front());
        for (int i = 0; i < n; i++) m_buf.push_back(m_stage.pop_front());
        if (w && rdy) begin
            top = -1;
            for (int j = 0; j < CC; j++) if (m[j]) top = j;
            for (int j = 0; j < CC; j++)
                if (m[j]) m_stage.push_back({(j == top), slice(d, j)});
        end
        if (w && !rdy) m_of = 1'b1;
        else if (c)    m_of = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [CC-1:0] m,
                         input logic [CC*CW-1:0] d, input logic r, input logic c);
        wren = w; clause_valid_i = m; clauses_i = d; rden = r; cOF = c;
        model_step(w, m, d, r, c);
        @(posedge clk); #1;
        wren = 1'b0; clause_valid_i = '0; clauses_i = '0; rden = 1'b0; cOF = 1'b0;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, '0, '0, r, 1'b0);
    endtask

    // Pops until both buffer and staging are empty, recording each output.
    task automatic drain_all(output bit timed_out);
        int b;
        b = 0;
        got.delete();
        got_last.delete();
        while (!(empty && ready) && b < 200) begin
            if (!empty) begin
                got.push_back(clause_o);
`ifdef CLAUSE_GATHER_LAST_TAG_EN
                got_last.push_back(clause_last_o);
`endif
            end
            idle(1'b1);
            b++;
        end
        timed_out = !(empty && ready);
    endtask

    task automatic test_reset();
        wren = 0; rden = 0; cOF = 0; clauses_i = '0; clause_valid_i = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (OF !== 1'b0) begin failures++; $display("FAIL reset_of got=%b exp=0", OF); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (clause_o !== 9'h000) begin failures++; $display("FAIL reset_clause got=%h exp=000", clause_o); end
        reset = 1'b0;
        idle(1'b0);
    endtask

    task automatic test_basic_order();
        logic [CC*CW-1:0] d;
        d = '0;
        d[0*CW +: CW] = 9'h011;
        d[1*CW +: CW] = 9'h022;
        d[4*CW +: CW] = 9'h044;
        drive(1'b1, 20'h00013, d, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty_at_accept got=%b exp=1", empty); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_busy got=%b exp=0", ready); end
        idle(1'b1);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_empty_fall got=%b exp=0", empty); end
        checks++; if (clause_o !== 9'h011) begin failures++; $display("FAIL basic_out0 got=%h exp=011", clause_o); end
        idle(1'b1);
        checks++; if (clause_o !== 9'h022) begin failures++; $display("FAIL basic_out1 got=%h exp=022", clause_o); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL basic_ready_return got=%b exp=1", ready); end
        idle(1'b1);
        checks++; if (clause_o !== 9'h044) begin failures++; $display("FAIL basic_out2 got=%h exp=044", clause_o); end
        idle(1'b1);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_final_empty got=%b exp=1", empty); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL basic_final_count got=%0d exp=0", count); end
    endtask

    task automatic test_backpressure();
        logic [CC*CW-1:0] d;
        logic [CW-1:0]    p0, p1;
        bit               to;
        int               b;
        d = rand_vec();
        drive(1'b1, 20'hFFFFF, d, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            idle(1'b0);
            checks++; if (count !== 5'(2*i)) begin failures++; $display("FAIL bp_fill_count step=%0d got=%0d exp=%0d", i, count, 2*i); end
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL bp_full got=%b exp=1", full); end
        idle(1'b0);
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL bp_hold_count got=%0d exp=16", count); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got=%b exp=0", ready); end
        p0 = clause_o; idle(1'b1);
        p1 = clause_o; idle(1'b1);
        checks++; if (p0 !== slice(d, 0)) begin failures++; $display("FAIL bp_pop0 got=%h exp=%h", p0, slice(d, 0)); end
        checks++; if (p1 !== slice(d, 1)) begin failures++; $display("FAIL bp_pop1 got=%h exp=%h", p1, slice(d, 1)); end
        b = 0;
        while (count !== 5'd16 && b < 10) begin idle(1'b0); b++; end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL bp_refill_full got=%b count=%0d exp=1", full, count); end
        drain_all(to);
        checks++; if (to) begin failures++; $display("FAIL bp_drain_timeout got=busy exp=drained"); end
        checks++; if (got.size() != 18) begin failures++; $display("FAIL bp_drain_size got=%0d exp=18", got.size()); end
        for (int i = 0; i < 18 && i < got.size(); i++) begin
            checks++; if (got[i] !== slice(d, i + 2)) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i + 2, got[i], slice(d, i + 2)); end
        end
        checks++; if (OF !== 1'b0) begin failures++; $display("FAIL bp_of got=%b exp=0", OF); end
    endtask

    task automatic test_overflow();
        logic [CC-1:0] m1;
        bit            to;
        m1 = CC'($urandom) | 20'h1;
        drive(1'b1, m1, rand_vec(), 1'b0, 1'b0);
        drive(1'b1, CC'($urandom) | 20'h2, rand_vec(), 1'b0, 1'b0);
        checks++; if (OF !== 1'b1) begin failures++; $display("FAIL of_set got=%b exp=1", OF); end
        repeat (3) idle(1'b0);
        checks++; if (OF !== 1'b1) begin failures++; $display("FAIL of_sticky got=%b exp=1", OF); end
        drain_all(to);
        checks++; if (to) begin failures++; $display("FAIL of_drain_timeout got=busy exp=drained"); end
        checks++; if (got.size() != $countones(m1)) begin failures++; $display("FAIL of_dropped_vector got=%0d exp=%0d", got.size(), $countones(m1)); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++; if (OF !== 1'b0) begin failures++; $display("FAIL of_clear got=%b exp=0", OF); end
        drive(1'b1, 20'h00F0F, rand_vec(), 1'b0, 1'b0);
        drive(1'b1, 20'h00001, rand_vec(), 1'b0, 1'b1);
        checks++; if (OF !== 1'b1) begin failures++; $display("FAIL of_set_wins got=%b exp=1", OF); end
        drain_all(to);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_batch_order();
        logic [CC*CW-1:0] da, db;
        logic [CW-1:0]    exp_q[4];
        bit               to;
        int               b;
        da = rand_vec(); db = rand_vec();
        exp_q[0] = slice(da, 0); exp_q[1] = slice(da, 8);
        exp_q[2] = slice(db, 0); exp_q[3] = slice(db, 1);
        drive(1'b1, 20'h00101, da, 1'b0, 1'b0);
        b = 0;
        while (!ready && b < 10) begin idle(1'b0); b++; end
        drive(1'b1, 20'h00003, db, 1'b0, 1'b0);
        drain_all(to);
        checks++; if (got.size() != 4) begin failures++; $display("FAIL batch_size got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL batch_order pos=%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midop();
        logic [CC*CW-1:0] d;
        logic [CC-1:0]    m;
        int               k;
        bit               to;
        drive(1'b1, 20'h001FF, rand_vec(), 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b1, 20'h00001, rand_vec(), 1'b1, 1'b0);
        checks++; if (count !== 5'd3) begin failures++; $display("FAIL midop_setup_count got=%0d exp=3", count); end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL midop_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midop_empty got=%b exp=1", empty); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midop_ready got=%b exp=1", ready); end
        checks++; if (clause_o !== 9'h000) begin failures++; $display("FAIL midop_clause got=%h exp=000", clause_o); end
        checks++; if (OF !== 1'b0) begin failures++; $display("FAIL midop_of got=%b exp=0", OF); end
        #2;
        reset = 1'b0;
        idle(1'b0);
        d = rand_vec();
        m = CC'($urandom) | 20'h80000;
        drive(1'b1, m, d, 1'b0, 1'b0);
        drain_all(to);
        checks++; if (got.size() != $countones(m)) begin failures++; $display("FAIL midop_new_size got=%0d exp=%0d", got.size(), $countones(m)); end
        k = 0;
        for (int j = 0; j < CC; j++) begin
            if (m[j] && k < got.size()) begin
                checks++; if (got[k] !== slice(d, j)) begin failures++; $display("FAIL midop_new_data idx=%0d got=%h exp=%h", j, got[k], slice(d, j)); end
                k++;
            end
        end
    endtask

`ifdef CLAUSE_GATHER_LAST_TAG_EN
    task automatic test_tag();
        bit to;
        drive(1'b1, 20'h80005, rand_vec(), 1'b0, 1'b0);
        drain_all(to);
        checks++; if (got_last.size() != 3) begin failures++; $display("FAIL tag_size got=%0d exp=3", got_last.size()); end
        for (int i = 0; i < 3 && i < got_last.size(); i++) begin
            checks++; if (got_last[i] !== (i == 2)) begin failures++; $display("FAIL tag_last pos=%0d got=%b exp=%b", i, got_last[i], (i == 2)); end
        end
        drive(1'b1, 20'h00000, rand_vec(), 1'b0, 1'b0);
        idle(1'b0);
        checks++; if (count !== 5'd0 || ready !== 1'b1) begin failures++; $display("FAIL tag_zero_mask got count=%0d ready=%b exp count=0 ready=1", count, ready); end
    endtask
`endif

    task automatic test_random();
        logic          w, r, c;
        logic [CC-1:0] m;
        logic [CW:0]   head;
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 3) == 0);
            m = ($urandom_range(0, 7) == 0) ? '0 : CC'($urandom);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 15) == 0);
            drive(w, m, rand_vec(), r, c);
            head = (m_buf.size() > 0) ? m_buf[0] : '0;
            checks++; if (count !== 5'(m_buf.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, m_buf.size()); end
            checks++; if (empty !== (m_buf.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", i, empty, (m_buf.size() == 0)); end
            checks++; if (full !== (m_buf.size() == BD)) begin failures++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", i, full, (m_buf.size() == BD)); end
            checks++; if (ready !== (m_stage.size() == 0)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, ready, (m_stage.size() == 0)); end
            checks++; if (OF !== m_of) begin failures++; $display("FAIL rnd_of cyc=%0d got=%b exp=%b", i, OF, m_of); end
            checks++; if (clause_o !== head[CW-1:0]) begin failures++; $display("FAIL rnd_clause cyc=%0d got=%h exp=%h", i, clause_o, head[CW-1:0]); end
`ifdef CLAUSE_GATHER_LAST_TAG_EN
            checks++; if (clause_last_o !== head[CW]) begin failures++; $display("FAIL rnd_last cyc=%0d got=%b exp=%b", i, clause_last_o, head[CW]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_backpressure();
        test_overflow();
        test_batch_order();
        test_reset_midop();
`ifdef CLAUSE_GATHER_LAST_TAG_EN
        test_tag();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/clause_gather_fifo.md
Name: clause_gather_fifo

Overview:
- Parametrised successor to the multi-level clause FIFO tree.
- Accepts a wide vector of CLAUSE_COUNT clauses plus a per-clause valid mask in one cycle and holds it in a staging register.
- Compacts the valid clauses into a single circular buffer, up to DRAIN_WIDTH per cycle, strictly in ascending input-index order.
- Presents one clause per cycle to the downstream consumer with first-word-fall-through reads, explicit input backpressure and a sticky overflow flag.

Parameters:
- CLAUSE_COUNT, 20: clauses per input vector.
- CLAUSE_WIDTH, 9: bits per clause.
- BUFFER_DEPTH, 16: buffer entries; power of two, ≥2.
- DRAIN_WIDTH, 2: maximum clauses moved from staging to buffer per cycle; 1..CLAUSE_COUNT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clauses_i  in  CLAUSE_COUNT*CLAUSE_WIDTH  clause j at bits [j*CLAUSE_WIDTH +: CLAUSE_WIDTH].
- clause_valid_i  in  CLAUSE_COUNT  bit j qualifies clause j.
- wren  in  1  load request for the input vector.
- ready  out  1  staging register empty; a wren is accepted this cycle.
- rden  in  1  pop the head clause.
- cOF  in  1  clear overflow.
- empty  out  1  buffer holds no clauses.
- full  out  1  buffer count equals BUFFER_DEPTH.
- OF  out  1  sticky overflow.
- count  out  $clog2(BUFFER_DEPTH+1)  buffer occupancy.
- clause_o  out  CLAUSE_WIDTH  head clause; 0 when empty.

Behaviour:
- Reset, asynchronous, any time, including mid-drain:
  - Clears staging mask, read/write pointers, count and OF.
  - Outputs: ready=1, empty=1, full=0, OF=0, count=0, clause_o=0.
  - Buffer RAM contents are not reset.
- Accept: at a rising edge with wren=1 and ready=1, latch clauses_i into stage_data and clause_valid_i into stage_mask.
  - An all-zero mask is accepted and has no further effect.
- ready = (stage_mask == 0). This is combinational from registers and does not look ahead at the drain in progress.
- Drop: wren=1 with ready=0 discards the input vector and sets OF at that edge.
- Drain, every cycle:
  - n = min(DRAIN_WIDTH, popcount(stage_mask), BUFFER_DEPTH − count).
  - Free slots use count before this cycle's pop, i.e. a conservative margin.
  - The n lowest-index set bits are written to consecutive buffer slots, lowest index first, and cleared from stage_mask.
- Latency:
  - Vector accepted at edge k.
  - First clauses written at edge k+1.
  - empty falls and clause_o is valid after edge k+1.
  - ready returns after the edge that clears the last mask bit.
- Read: clause_o = buffer[rd_ptr] while count>0.
  - rden=1 and empty=0 pops at the edge.
  - rden=1 with empty=1 is ignored: no state change, no flag.
- count(next) = count + n − pop. A simultaneous write and pop is legal.
- Pointers wrap modulo BUFFER_DEPTH.
- full: staging holds its remaining bits and waits. Nothing is lost while full; only drops set OF.
- cOF=1 clears OF at the edge. If a drop occurs in the same cycle, set wins and OF=1.
- Ordering:
  - Clauses of batch A are all output before any clause of a later batch B.
  - Within a batch, clauses are output in ascending index order.

Optional Feature:
- Macro: CLAUSE_GATHER_LAST_TAG_EN.
- Defined:
  - Adds output clause_last_o (1 bit).
  - Each buffer entry stores a tag that is 1 only for the highest-index valid clause of its batch.
  - clause_last_o follows clause_o and is 0 when empty. Reset value 0.
- Undefined: port and tag storage are absent; all other behaviour is identical.

Test Plan:
- Basic order: defaults, stage_mask=20'h00013 with clauses 0x011/0x022/0x044 at indices 0/1/4, rden held 1. Expected:
  - empty falls one cycle after accept.
  - clause_o sequence 0x011, 0x022, 0x044, then empty=1, count=0.
  - ready returns after 2 cycles.
- Backpressure/full: mask 20'hFFFFF, rden=0. Expected:
  - count rises 2 per cycle to 16, then full=1.
  - 4 clauses remain staged and ready=0 persists.
  - Pop 2 clauses; the buffer refills to 16.
  - Drain everything: all 20 clauses out in index order 0..19, OF=0.
- Overflow: two consecutive wren cycles with nonzero masks. Expected:
  - Second vector dropped, OF=1, and it stays 1.
  - Pulse cOF → OF=0 next cycle.
  - cOF coincident with another drop → OF stays 1.
- Batch ordering: batch A mask 20'h00101, then after ready batch B mask 20'h00003 → outputs A[0], A[8], B[0], B[1].
- Reset mid-operation: assert reset asynchronously (off-edge) while 3 clauses are buffered and 5 are staged. Expected:
  - Immediately count=0, empty=1, ready=1, clause_o=0, OF=0.
  - After deassert, a new batch outputs correctly with no stale data.
- Tag (macro defined): mask 20'h80005 → clause_last_o = 0, 0, 1 on the three outputs; all-zero mask produces no entries.
